cbi980_seq: RTL and testbench



---
 rtl/cbi980_seq.sv | 195 +++++++++++++++++++
 tb/tb_cbi980_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbi980_seq.sv
// cbi980_seq: autonomous register-port sequencer for cbi980_core.
// It writes CR_VALUE to CR, polls SR until the codec reports init, and then
// loops. Each loop polls SR once and moves at most one sample:
//   - RX: DIN FIFO -> m_t* stream
//   - TX: s_t* stream -> DOUT FIFO
// When both RX FIFOs hold data, the two channels are served alternately.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   enable                       run (high) / graceful stop (low)
//   s_tdata/s_tchan/s_tvalid/s_tready   TX sample stream in
//   m_tdata/m_tchan/m_tvalid/m_tready   RX sample stream out
//   core_wr_addr/data/en, core_wr_err   core write port
//   core_rd_addr/req, core_rd_data/ack  core read port (latency 1)
//   running                      high while in the poll/transfer loop
//   err, ovf[1:0], unf[1:0]      sticky status, cleared on configuration
module cbi980_seq #(
  parameter logic [31:0] CR_VALUE = 32'h0000_003C,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] s_tdata,
  input  logic        s_tchan,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [31:0] m_tdata,
  output logic        m_tchan,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [2:0]  core_wr_addr,
  output logic [31:0] core_wr_data,
  output logic        core_wr_en,
  input  logic        core_wr_err,
  output logic [2:0]  core_rd_addr,
  output logic        core_rd_req,
  input  logic [31:0] core_rd_data,
  input  logic        core_rd_ack,
  output logic        running,
  output logic        err,
  output logic [1:0]  ovf,
  output logic [1:0]  unf
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_INIT_RD, S_INIT_WT, S_POLL, S_POLL_WT, S_DECIDE,
    S_RD, S_RD_WT, S_PUSH, S_WR, S_GAP, S_STOP
  } state_t;

  localparam logic [2:0] A_SR = 3'd1, A_CR = 3'd2;

  // GAP occupies POLL_GAP cycles (at least one), so the counter is preloaded
  // with POLL_GAP-1 and the exit is taken in the cycle it reads zero.
  localparam logic [7:0] GAP_LOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  state_t     state, next_state;
  logic [1:0] rxne, txnf;      // SR flags from the latest poll
  logic       rr;              // last served RX channel
  logic       rd_ch;           // channel being read
  logic [7:0] gap_cnt;
  logic       pick_ch, go_rx, go_tx;

  assign go_rx   = |rxne;
  assign go_tx   = s_tvalid && txnf[s_tchan];
  // Both pending: alternate away from the last served channel.
  assign pick_ch = (rxne == 2'b11) ? ~rr : rxne[1];

  always_comb begin
    next_state   = state;
    s_tready     = 1'b0;
    core_wr_en   = 1'b0;
    core_wr_addr = '0;
    core_wr_data = '0;
    core_rd_req  = 1'b0;
    core_rd_addr = '0;
    running      = 1'b0;
    case (state)
      S_IDLE:    if (enable) next_state = S_CFG;
      S_CFG: begin
        core_wr_en   = 1'b1;
        core_wr_addr = A_CR;
        core_wr_data = CR_VALUE;
        next_state   = S_INIT_RD;
      end
      S_INIT_RD: begin
        core_rd_req  = 1'b1;
        core_rd_addr = A_SR;
        next_state   = S_INIT_WT;
      end
      S_INIT_WT: if (core_rd_ack) next_state = core_rd_data[31] ? S_GAP : S_INIT_RD;
      S_POLL: begin
        running      = 1'b1;
        core_rd_req  = 1'b1;
        core_rd_addr = A_SR;
        next_state   = S_POLL_WT;
      end
      S_POLL_WT: begin
        running = 1'b1;
        if (core_rd_ack) next_state = S_DECIDE;
      end
      S_DECIDE: begin
        running = 1'b1;
        if (!enable)    next_state = S_STOP;
        else if (go_rx) next_state = S_RD;
        else if (go_tx) next_state = S_WR;
        else            next_state = S_GAP;
      end
      S_RD: begin
        running      = 1'b1;
        core_rd_req  = 1'b1;
        core_rd_addr = rd_ch ? 3'd6 : 3'd7;
        next_state   = S_RD_WT;
      end
      S_RD_WT: begin
        running = 1'b1;
        if (core_rd_ack) next_state = S_PUSH;
      end
      S_PUSH: begin
        running = 1'b1;
        if (m_tready) next_state = S_GAP;
      end
      S_WR: begin
        running      = 1'b1;
        s_tready     = 1'b1;
        core_wr_en   = 1'b1;
        core_wr_addr = s_tchan ? 3'd4 : 3'd5;
        core_wr_data = s_tdata;
        next_state   = S_GAP;
      end
      S_GAP: begin
        running = 1'b1;
        if (!enable)           next_state = S_STOP;
        else if (gap_cnt == 0) next_state = S_POLL;
      end
      S_STOP: begin
        core_wr_en   = 1'b1;
        core_wr_addr = A_CR;
        next_state   = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      rxne     <= '0;
      txnf     <= '0;
      rr       <= 1'b0;
      rd_ch    <= 1'b0;
      gap_cnt  <= '0;
      m_tdata  <= '0;
      m_tchan  <= 1'b0;
      m_tvalid <= 1'b0;
      err      <= 1'b0;
      ovf      <= '0;
      unf      <= '0;
    end else begin
      state <= next_state;
      if (core_wr_en && core_wr_err) err <= 1'b1;
      if (next_state == S_GAP && state != S_GAP) gap_cnt <= GAP_LOAD;
      case (state)
        S_CFG: begin
          err <= core_wr_err;
          ovf <= '0;
          unf <= '0;
        end
        S_POLL_WT: if (core_rd_ack) begin
          txnf <= {core_rd_data[13], core_rd_data[9]};
          rxne <= {core_rd_data[15], core_rd_data[11]};
          ovf  <= ovf | {core_rd_data[19], core_rd_data[17]};
          unf  <= unf | {core_rd_data[18], core_rd_data[16]};
        end
        S_DECIDE: begin
          if (enable && go_rx) begin
            rr    <= pick_ch;
            rd_ch <= pick_ch;
          end
          // Flags are consumed by this decision only.
          rxne <= '0;
          txnf <= '0;
        end
        S_RD_WT: if (core_rd_ack) begin
          m_tdata  <= core_rd_data;
          m_tchan  <= rd_ch;
          m_tvalid <= 1'b1;
        end
        S_PUSH:  if (m_tready) m_tvalid <= 1'b0;
        S_GAP:   if (gap_cnt != 0) gap_cnt <= gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cbi980_seq.sv
// Testbench for cbi980_seq. A behavioural core answers register reads one
// cycle after the request. It returns queued SR words, or random DIN samples
// whose expected {chan, data} go to a scoreboard checked at each RX handshake.
module tb_cbi980_seq;
  localparam logic [31:0] CRV = 32'h0000_003C;

  logic        clk = 1'b0;
  logic        rstn, enable;
  logic [31:0] s_tdata;
  logic        s_tchan, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tchan, m_tvalid, m_tready;
  logic [2:0]  core_wr_addr, core_rd_addr;
  logic [31:0] core_wr_data;
  logic        core_wr_en, core_rd_req;
  logic        core_wr_err = 1'b0;
  logic [31:0] core_rd_data = '0;
  logic        core_rd_ack = 1'b0;
  logic        running, err;
  logic [1:0]  ovf, unf;

  cbi980_seq #(.CR_VALUE(CRV), .POLL_GAP(4)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .s_tdata(s_tdata), .s_tchan(s_tchan), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tchan(m_tchan), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data), .core_wr_en(core_wr_en),
    .core_wr_err(core_wr_err), .core_rd_addr(core_rd_addr), .core_rd_req(core_rd_req),
    .core_rd_data(core_rd_data), .core_rd_ack(core_rd_ack),
    .running(running), .err(err), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t        wr_obs[$];
  acc_t        rd_obs[$];
  logic [31:0] sr_q[$];
  logic [32:0] rx_exp[$];
  int          chan_log[$];
  int          cyc = 0;
  int          rx_done = 0;
  logic        err_inject = 1'b0;
  logic        req_seen = 1'b0;
  logic [2:0]  req_addr = '0;

  // Monitor and core model, both on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (core_wr_en || core_rd_req)
      check("strobe_excl", 32'(core_wr_en & core_rd_req), 32'd0);
    if (core_wr_en) wr_obs.push_back('{core_wr_addr, core_wr_data, cyc});
    if (core_rd_req) rd_obs.push_back('{core_rd_addr, 32'd0, cyc});
    if (m_tvalid && m_tready) begin
      if (rx_exp.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else begin
        e = rx_exp.pop_front();
        check("rx_data", m_tdata, e[31:0]);
        check("rx_chan", 32'(m_tchan), 32'(e[32]));
      end
      chan_log.push_back(int'(m_tchan));
      rx_done++;
    end
    core_wr_err = err_inject && core_wr_en;
    core_rd_ack = 1'b0;
    if (req_seen) begin
      core_rd_ack = 1'b1;
      if (req_addr == 3'd1)
        core_rd_data = (sr_q.size() != 0) ? sr_q.pop_front() : 32'h8000_0000;
      else begin
        core_rd_data = $urandom;
        rx_exp.push_back({req_addr == 3'd6, core_rd_data});
      end
    end
    req_seen = core_rd_req;
    req_addr = core_rd_addr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_tready(input logic v);
    @(posedge clk);
    #1 m_tready = v;
  endtask

  initial begin
    int n, k, base, nrd, nwr;
    int din[$];
    logic stable;
    logic [31:0] d0;
    logic c0;
    rstn = 1'b0; enable = 1'b0; s_tdata = '0; s_tchan = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    repeat (3) tick();
    check("rst_running", 32'(running), 0);
    check("rst_mvalid", 32'(m_tvalid), 0);
    check("rst_mdata", m_tdata, 0);
    check("rst_strobes", 32'({core_wr_en, core_rd_req, s_tready}), 0);
    check("rst_buses", 32'({core_wr_addr, core_rd_addr}) | core_wr_data, 0);
    check("rst_status", 32'({err, ovf, unf}), 0);

    // Start-up: two not-ready SR reads, then init.
    rstn = 1'b1;
    tick();
    wr_obs.delete(); rd_obs.delete();
    sr_q.push_back(32'h0); sr_q.push_back(32'h0); sr_q.push_back(32'h8000_0000);
    enable = 1'b1;
    for (n = 0; n < 200 && !running; n++) tick();
    check("init_running", 32'(running), 1);
    check("init_wr_cnt", 32'(wr_obs.size()), 1);
    check("init_cr_addr", 32'(wr_obs[0].addr), 2);
    check("init_cr_data", wr_obs[0].data, CRV);
    check("init_sr_reads", 32'(rd_obs.size()), 3);
    check("init_err", 32'(err), 0);

    // TX on channel 0.
    wr_obs.delete(); rd_obs.delete();
    s_tdata = 32'h00AB_CDEF; s_tchan = 1'b0; s_tvalid = 1'b1;
    sr_q.push_back(32'h8000_0200);
    for (n = 0; n < 200 && !s_tready; n++) tick();
    check("tx_tready", 32'(s_tready), 1);
    check("tx_wr_en", 32'(core_wr_en), 1);
    check("tx_addr", 32'(core_wr_addr), 5);
    check("tx_data", core_wr_data, 32'h00AB_CDEF);
    tick();
    s_tvalid = 1'b0;
    check("tx_tready_pulse", 32'(s_tready), 0);
    for (n = 1; n < 50 && !core_rd_req; n++) tick();
    check("tx_gap", 32'(n), 5);
    check("tx_next_sr", 32'(core_rd_addr), 1);
    check("tx_wr_cnt", 32'(wr_obs.size()), 1);

    // Both RX FIFOs pending for four polls: channels alternate, starting at ch1.
    set_tready(1'b1);
    tick();
    rd_obs.delete(); chan_log.delete();
    base = rx_done;
    repeat (4) sr_q.push_back(32'h8000_8800);
    for (n = 0; n < 400 && rx_done < base + 4; n++) tick();
    check("alt_count", 32'(rx_done - base), 4);
    foreach (rd_obs[i]) if (rd_obs[i].addr != 3'd1) din.push_back(int'(rd_obs[i].addr));
    check("alt_rd_cnt", 32'(din.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("alt_addr", 32'(din[i]), (i % 2 == 0) ? 32'd6 : 32'd7);
      check("alt_chan", 32'(chan_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    k = 1;
    while (k < rd_obs.size() - 1 && rd_obs[k].addr == 3'd1) k++;
    check("rx_sr_to_rd", 32'(rd_obs[k].cyc - rd_obs[k-1].cyc), 3);
    check("rx_loop", 32'(rd_obs[k+1].cyc - rd_obs[k-1].cyc), 10);

    // Backpressure on RX channel 0.
    set_tready(1'b0);
    sr_q.push_back(32'h8000_0800);
    for (n = 0; n < 200 && !m_tvalid; n++) tick();
    check("bp_mvalid", 32'(m_tvalid), 1);
    d0 = m_tdata; c0 = m_tchan;
    nrd = rd_obs.size(); nwr = wr_obs.size();
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!m_tvalid || m_tdata !== d0 || m_tchan !== c0) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_chan", 32'(c0), 0);
    check("bp_no_rd", 32'(rd_obs.size()), 32'(nrd));
    check("bp_no_wr", 32'(wr_obs.size()), 32'(nwr));
    base = rx_done;
    set_tready(1'b1);
    for (n = 0; n < 50 && rx_done == base; n++) tick();
    check("bp_done", 32'(rx_done - base), 1);

    // Sticky rx_ovf0 + tx_unf1.
    sr_q.push_back(32'h8006_0000);
    repeat (40) tick();
    check("sticky_ovf", 32'(ovf), 32'b01);
    check("sticky_unf", 32'(unf), 32'b10);
    repeat (20) tick();
    check("sticky_ovf_hold", 32'(ovf), 32'b01);
    check("sticky_unf_hold", 32'(unf), 32'b10);

    // enable falls during PUSH.
    set_tready(1'b0);
    sr_q.push_back(32'h8000_8000);
    for (n = 0; n < 200 && !m_tvalid; n++) tick();
    enable = 1'b0;
    repeat (3) tick();
    check("stop_push_hold", 32'(m_tvalid), 1);
    check("stop_push_running", 32'(running), 1);
    wr_obs.delete(); rd_obs.delete();
    base = rx_done;
    set_tready(1'b1);
    for (n = 0; n < 50 && running; n++) tick();
    check("stop_running", 32'(running), 0);
    check("stop_rx_done", 32'(rx_done - base), 1);
    check("stop_wr_cnt", 32'(wr_obs.size()), 1);
    check("stop_cr_addr", 32'(wr_obs[0].addr), 2);
    check("stop_cr_data", wr_obs[0].data, 0);
    repeat (10) tick();
    check("idle_wr_cnt", 32'(wr_obs.size()), 1);
    check("idle_rd_cnt", 32'(rd_obs.size()), 0);
    check("stop_ovf_kept", 32'(ovf), 32'b01);

    // Write error during CFG; CFG clears ovf/unf.
    err_inject = 1'b1;
    sr_q.push_back(32'h8000_0000);
    enable = 1'b1;
    for (n = 0; n < 100 && !running; n++) tick();
    err_inject = 1'b0;
    check("cfg_running", 32'(running), 1);
    check("cfg_err", 32'(err), 1);
    check("cfg_clr_ovf", 32'(ovf), 0);
    check("cfg_clr_unf", 32'(unf), 0);

    // Async reset mid-PUSH drops m_tvalid without a clock edge.
    set_tready(1'b0);
    sr_q.push_back(32'h8000_0800);
    for (n = 0; n < 200 && !m_tvalid; n++) tick();
    check("rstpush_mvalid", 32'(m_tvalid), 1);
    rstn = 1'b0;
    #1;
    check("rstpush_drop", 32'(m_tvalid), 0);
    check("rstpush_running", 32'(running), 0);
    check("rstpush_err", 32'(err), 0);
    enable = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
